// File: rtl/alu_rs_if.sv
// alu_rs_if: dispatch, CDB and ALU-issue bundle for the ALU reservation station.
// master = upstream/dispatch + CDB source + ALU sink; slave = the station.
interface alu_rs_if #(
    parameter int TAG_W = 4,
    parameter int OP_W  = 6,
    parameter int XLEN  = 32
);
    logic             disp_valid;
    logic [OP_W-1:0]  disp_op;
    logic [XLEN-1:0]  disp_vj;
    logic [TAG_W-1:0] disp_qj;
    logic             disp_qj_busy;
    logic [XLEN-1:0]  disp_vk;
    logic [TAG_W-1:0] disp_qk;
    logic             disp_qk_busy;
    logic [TAG_W-1:0] disp_rob;
    logic             full;

    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_val;

    logic             alu_status;
    logic [OP_W-1:0]  alu_op;
    logic [XLEN-1:0]  alu_rs1;
    logic [XLEN-1:0]  alu_rs2;
    logic [TAG_W-1:0] alu_rob;

    modport master (
        output disp_valid, disp_op, disp_vj, disp_qj, disp_qj_busy,
        output disp_vk, disp_qk, disp_qk_busy, disp_rob,
        output cdb_valid, cdb_tag, cdb_val,
        input  full, alu_status, alu_op, alu_rs1, alu_rs2, alu_rob
    );

    modport slave (
        input  disp_valid, disp_op, disp_vj, disp_qj, disp_qj_busy,
        input  disp_vk, disp_qk, disp_qk_busy, disp_rob,
        input  cdb_valid, cdb_tag, cdb_val,
        output full, alu_status, alu_op, alu_rs1, alu_rs2, alu_rob
    );
endinterface

// File: rtl/alu_rs.sv
// alu_rs: reservation station for the integer ALU. Buffers dispatched ops,
// snoops the CDB for missing operands, issues the lowest-index ready slot.
// Ports: clk_in, rst_in (sync, active high), rdy_in (freeze), clear (flush),
// bus (alu_rs_if.slave: dispatch, full, CDB, ALU issue outputs).
module alu_rs #(
    parameter int ENTRIES = 8,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 6,
    parameter int XLEN    = 32
) (
    input  logic   clk_in,
    input  logic   rst_in,
    input  logic   rdy_in,
    input  logic   clear,
    alu_rs_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] busy_q, busy_d;
    logic [ENTRIES-1:0] qjb_q, qjb_d;
    logic [ENTRIES-1:0] qkb_q, qkb_d;
    logic [OP_W-1:0]    op_q  [ENTRIES];
    logic [OP_W-1:0]    op_d  [ENTRIES];
    logic [XLEN-1:0]    vj_q  [ENTRIES];
    logic [XLEN-1:0]    vj_d  [ENTRIES];
    logic [XLEN-1:0]    vk_q  [ENTRIES];
    logic [XLEN-1:0]    vk_d  [ENTRIES];
    logic [TAG_W-1:0]   qj_q  [ENTRIES];
    logic [TAG_W-1:0]   qj_d  [ENTRIES];
    logic [TAG_W-1:0]   qk_q  [ENTRIES];
    logic [TAG_W-1:0]   qk_d  [ENTRIES];
    logic [TAG_W-1:0]   rob_q [ENTRIES];
    logic [TAG_W-1:0]   rob_d [ENTRIES];

    logic               st_q, st_d;
    logic [OP_W-1:0]    aop_q, aop_d;
    logic [XLEN-1:0]    rs1_q, rs1_d;
    logic [XLEN-1:0]    rs2_q, rs2_d;
    logic [TAG_W-1:0]   arob_q, arob_d;

    logic [ENTRIES-1:0] ready;
    logic               iss_vld;
    logic [IDX_W-1:0]   iss_idx;
    logic               free_vld;
    logic [IDX_W-1:0]   free_idx;
    logic               disp_we;
    logic               j_byp;
    logic               k_byp;

    // Readiness uses registered state only, so a CDB capture wakes the
    // slot one cycle later.
    assign ready = busy_q & ~qjb_q & ~qkb_q;

    // Fixed-priority pickers: descending scan leaves the lowest index.
    always_comb begin
        iss_vld  = 1'b0;
        iss_idx  = '0;
        free_vld = 1'b0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (ready[i]) begin
                iss_vld = 1'b1;
                iss_idx = IDX_W'(i);
            end
            if (!busy_q[i]) begin
                free_vld = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // Free slot comes from registered busy, so a slot issued this cycle
    // cannot be refilled until the next one.
    assign disp_we = bus.disp_valid & free_vld;
    assign j_byp   = bus.cdb_valid && (bus.cdb_tag == bus.disp_qj);
    assign k_byp   = bus.cdb_valid && (bus.cdb_tag == bus.disp_qk);

    always_comb begin
        busy_d = busy_q;
        qjb_d  = qjb_q;
        qkb_d  = qkb_q;
        op_d   = op_q;
        vj_d   = vj_q;
        vk_d   = vk_q;
        qj_d   = qj_q;
        qk_d   = qk_q;
        rob_d  = rob_q;

        for (int i = 0; i < ENTRIES; i++) begin
            if (busy_q[i] && bus.cdb_valid) begin
                if (qjb_q[i] && qj_q[i] == bus.cdb_tag) begin
                    vj_d[i]  = bus.cdb_val;
                    qjb_d[i] = 1'b0;
                end
                if (qkb_q[i] && qk_q[i] == bus.cdb_tag) begin
                    vk_d[i]  = bus.cdb_val;
                    qkb_d[i] = 1'b0;
                end
            end
        end

        if (iss_vld) begin
            busy_d[iss_idx] = 1'b0;
        end

        if (disp_we) begin
            busy_d[free_idx] = 1'b1;
            op_d[free_idx]   = bus.disp_op;
            rob_d[free_idx]  = bus.disp_rob;
            qj_d[free_idx]   = bus.disp_qj;
            qk_d[free_idx]   = bus.disp_qk;
            // Same-cycle CDB bypass so the op does not wait for a
            // broadcast it has just missed.
            if (bus.disp_qj_busy && j_byp) begin
                vj_d[free_idx]  = bus.cdb_val;
                qjb_d[free_idx] = 1'b0;
            end else begin
                vj_d[free_idx]  = bus.disp_vj;
                qjb_d[free_idx] = bus.disp_qj_busy;
            end
            if (bus.disp_qk_busy && k_byp) begin
                vk_d[free_idx]  = bus.cdb_val;
                qkb_d[free_idx] = 1'b0;
            end else begin
                vk_d[free_idx]  = bus.disp_vk;
                qkb_d[free_idx] = bus.disp_qk_busy;
            end
        end

        if (clear) begin
            busy_d = '0;
        end
    end

    always_comb begin
        st_d   = iss_vld & ~clear;
        aop_d  = aop_q;
        rs1_d  = rs1_q;
        rs2_d  = rs2_q;
        arob_d = arob_q;
        if (iss_vld && !clear) begin
            aop_d  = op_q[iss_idx];
            rs1_d  = vj_q[iss_idx];
            rs2_d  = vk_q[iss_idx];
            arob_d = rob_q[iss_idx];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q <= '0;
            st_q   <= 1'b0;
            aop_q  <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            arob_q <= '0;
        end else if (rdy_in) begin
            busy_q <= busy_d;
            st_q   <= st_d;
            aop_q  <= aop_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
            arob_q <= arob_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in) begin
            qjb_q <= qjb_d;
            qkb_q <= qkb_d;
            op_q  <= op_d;
            vj_q  <= vj_d;
            vk_q  <= vk_d;
            qj_q  <= qj_d;
            qk_q  <= qk_d;
            rob_q <= rob_d;
        end
    end

    assign bus.full       = &busy_q;
    assign bus.alu_status = st_q;
    assign bus.alu_op     = aop_q;
    assign bus.alu_rs1    = rs1_q;
    assign bus.alu_rs2    = rs2_q;
    assign bus.alu_rob    = arob_q;
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed checks of the ALU reservation station.
// Inputs change 1 time unit after the rising edge; outputs sampled there too.
module tb_alu_rs;
    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic clear;
    int   n_tests = 0;
    int   n_fail  = 0;

    alu_rs_if #(.TAG_W(4), .OP_W(6), .XLEN(32)) bus ();

    alu_rs #(.ENTRIES(8), .TAG_W(4), .OP_W(6), .XLEN(32)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .clear  (clear),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        bus.disp_valid   = 1'b0;
        bus.disp_op      = '0;
        bus.disp_vj      = '0;
        bus.disp_qj      = '0;
        bus.disp_qj_busy = 1'b0;
        bus.disp_vk      = '0;
        bus.disp_qk      = '0;
        bus.disp_qk_busy = 1'b0;
        bus.disp_rob     = '0;
        bus.cdb_valid    = 1'b0;
        bus.cdb_tag      = '0;
        bus.cdb_val      = '0;
    endtask

    task automatic disp(input logic [5:0] op, input logic [31:0] vj,
                        input logic [3:0] qj, input logic qjb,
                        input logic [31:0] vk, input logic [3:0] qk,
                        input logic qkb, input logic [3:0] rob);
        bus.disp_valid   = 1'b1;
        bus.disp_op      = op;
        bus.disp_vj      = vj;
        bus.disp_qj      = qj;
        bus.disp_qj_busy = qjb;
        bus.disp_vk      = vk;
        bus.disp_qk      = qk;
        bus.disp_qk_busy = qkb;
        bus.disp_rob     = rob;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] val);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = tag;
        bus.cdb_val   = val;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        rdy_in = 1'b1;
        clear  = 1'b0;
        idle();
        tick();
        tick();
        rst_in = 1'b0;
        n_tests++;
        if (bus.alu_status !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status got %0b exp 0", bus.alu_status);
        end
        n_tests++;
        if (bus.full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_full got %0b exp 0", bus.full);
        end
        n_tests++;
        if (bus.alu_op !== 6'd0 || bus.alu_rob !== 4'd0 ||
            bus.alu_rs1 !== 32'd0 || bus.alu_rs2 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data got op=%h rob=%h rs1=%h rs2=%h exp all 0",
                     bus.alu_op, bus.alu_rob, bus.alu_rs1, bus.alu_rs2);
        end
    endtask

    task automatic test_ready_dispatch();
        disp(6'h01, 32'd5, 4'd0, 1'b0, 32'd7, 4'd0, 1'b0, 4'd3);
        tick();
        idle();
        n_tests++;
        if (bus.alu_status !== 1'b0 || bus.full !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_disp_edge got st=%0b full=%0b exp 0 0",
                     bus.alu_status, bus.full);
        end
        tick();
        n_tests++;
        if (bus.alu_status !== 1'b1 || bus.alu_rs1 !== 32'd5 ||
            bus.alu_rs2 !== 32'd7 || bus.alu_rob !== 4'd3 ||
            bus.alu_op !== 6'h01 || bus.full !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_issue got st=%0b op=%h rs1=%0d rs2=%0d rob=%0d full=%0b exp 1 01 5 7 3 0",
                     bus.alu_status, bus.alu_op, bus.alu_rs1, bus.alu_rs2,
                     bus.alu_rob, bus.full);
        end
        tick();
        n_tests++;
        if (bus.alu_status !== 1'b0 || bus.full !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_after got st=%0b full=%0b exp 0 0",
                     bus.alu_status, bus.full);
        end
    endtask

    task automatic test_cdb_wakeup();
        disp(6'h02, 32'hDEAD, 4'd2, 1'b1, 32'd1, 4'd0, 1'b0, 4'd4);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (bus.alu_status !== 1'b0) begin
                n_fail++;
                $display("FAIL wake_wait%0d got st=%0b exp 0", i, bus.alu_status);
            end
        end
        cdb(4'd2, 32'h10);
        tick();
        idle();
        n_tests++;
        if (bus.alu_status !== 1'b0) begin
            n_fail++;
            $display("FAIL wake_capture got st=%0b exp 0", bus.alu_status);
        end
        tick();
        n_tests++;
        if (bus.alu_status !== 1'b1 || bus.alu_rs1 !== 32'h10 ||
            bus.alu_rs2 !== 32'd1 || bus.alu_rob !== 4'd4) begin
            n_fail++;
            $display("FAIL wake_issue got st=%0b rs1=%h rs2=%h rob=%0d exp 1 10 1 4",
                     bus.alu_status, bus.alu_rs1, bus.alu_rs2, bus.alu_rob);
        end
        tick();
        n_tests++;
        if (bus.alu_status !== 1'b0) begin
            n_fail++;
            $display("FAIL wake_after got st=%0b exp 0", bus.alu_status);
        end
    endtask

    task automatic test_bypass();
        disp(6'h03, 32'h1, 4'd6, 1'b1, 32'h2, 4'd6, 1'b1, 4'd5);
        cdb(4'd6, 32'hAA);
        tick();
        idle();
        tick();
        n_tests++;
        if (bus.alu_status !== 1'b1 || bus.alu_rs1 !== 32'hAA ||
            bus.alu_rs2 !== 32'hAA || bus.alu_rob !== 4'd5) begin
            n_fail++;
            $display("FAIL bypass got st=%0b rs1=%h rs2=%h rob=%0d exp 1 aa aa 5",
                     bus.alu_status, bus.alu_rs1, bus.alu_rs2, bus.alu_rob);
        end
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            disp(6'h04, 32'd0, 4'd9, 1'b1, 32'(i), 4'd0, 1'b0, 4'(i));
            tick();
        end
        disp(6'h05, 32'h33, 4'd0, 1'b0, 32'h44, 4'd0, 1'b0, 4'd15);
        n_tests++;
        if (bus.full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_set got %0b exp 1", bus.full);
        end
        tick();
        idle();
        n_tests++;
        if (bus.full !== 1'b1 || bus.alu_status !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drop got full=%0b st=%0b exp 1 0",
                     bus.full, bus.alu_status);
        end
        cdb(4'd9, 32'd1);
        tick();
        idle();
        for (int k = 0; k < 8; k++) begin
            tick();
            n_tests++;
            if (bus.alu_status !== 1'b1 || bus.alu_rob !== 4'(k) ||
                bus.alu_rs1 !== 32'd1 || bus.alu_rs2 !== 32'(k)) begin
                n_fail++;
                $display("FAIL full_issue%0d got st=%0b rob=%0d rs1=%0d rs2=%0d exp 1 %0d 1 %0d",
                         k, bus.alu_status, bus.alu_rob, bus.alu_rs1,
                         bus.alu_rs2, k, k);
            end
            if (k == 0) begin
                n_tests++;
                if (bus.full !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_drop_after_issue got %0b exp 0", bus.full);
                end
            end
        end
        tick();
        n_tests++;
        if (bus.alu_status !== 1'b0) begin
            n_fail++;
            $display("FAIL full_no_ninth got st=%0b rob=%0d exp 0",
                     bus.alu_status, bus.alu_rob);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 3; i++) begin
            disp(6'h06, 32'd0, 4'd5, 1'b1, 32'd3, 4'd0, 1'b0, 4'(8 + i));
            tick();
        end
        disp(6'h07, 32'h9, 4'd0, 1'b0, 32'h9, 4'd0, 1'b0, 4'd11);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        idle();
        n_tests++;
        if (bus.full !== 1'b0 || bus.alu_status !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_edge got full=%0b st=%0b exp 0 0",
                     bus.full, bus.alu_status);
        end
        cdb(4'd5, 32'h77);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (bus.alu_status !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_no_issue%0d got st=%0b rob=%0d exp 0",
                         i, bus.alu_status, bus.alu_rob);
            end
        end
    endtask

    task automatic test_rdy();
        rdy_in = 1'b0;
        disp(6'h08, 32'h11, 4'd0, 1'b0, 32'h22, 4'd0, 1'b0, 4'd7);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (bus.alu_status !== 1'b0 || bus.full !== 1'b0) begin
                n_fail++;
                $display("FAIL rdy_frozen%0d got st=%0b full=%0b exp 0 0",
                         i, bus.alu_status, bus.full);
            end
        end
        rdy_in = 1'b1;
        tick();
        idle();
        n_tests++;
        if (bus.alu_status !== 1'b0) begin
            n_fail++;
            $display("FAIL rdy_disp got st=%0b exp 0", bus.alu_status);
        end
        tick();
        n_tests++;
        if (bus.alu_status !== 1'b1 || bus.alu_rob !== 4'd7 ||
            bus.alu_rs1 !== 32'h11 || bus.alu_rs2 !== 32'h22) begin
            n_fail++;
            $display("FAIL rdy_issue got st=%0b rob=%0d rs1=%h rs2=%h exp 1 7 11 22",
                     bus.alu_status, bus.alu_rob, bus.alu_rs1, bus.alu_rs2);
        end
        disp(6'h09, 32'hA1, 4'd0, 1'b0, 32'hA2, 4'd0, 1'b0, 4'd1);
        tick();
        disp(6'h0A, 32'hB1, 4'd0, 1'b0, 32'hB2, 4'd0, 1'b0, 4'd2);
        tick();
        idle();
        rdy_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if (bus.alu_status !== 1'b1 || bus.alu_rob !== 4'd1 ||
                bus.alu_rs1 !== 32'hA1) begin
                n_fail++;
                $display("FAIL rdy_hold%0d got st=%0b rob=%0d rs1=%h exp 1 1 a1",
                         i, bus.alu_status, bus.alu_rob, bus.alu_rs1);
            end
        end
        rdy_in = 1'b1;
        tick();
        n_tests++;
        if (bus.alu_status !== 1'b1 || bus.alu_rob !== 4'd2 ||
            bus.alu_rs1 !== 32'hB1 || bus.alu_rs2 !== 32'hB2) begin
            n_fail++;
            $display("FAIL rdy_resume got st=%0b rob=%0d rs1=%h rs2=%h exp 1 2 b1 b2",
                     bus.alu_status, bus.alu_rob, bus.alu_rs1, bus.alu_rs2);
        end
        tick();
        n_tests++;
        if (bus.alu_status !== 1'b0 || bus.alu_rob !== 4'd2) begin
            n_fail++;
            $display("FAIL rdy_idle_hold got st=%0b rob=%0d exp 0 2",
                     bus.alu_status, bus.alu_rob);
        end
    endtask

    initial begin
        test_reset();
        test_ready_dispatch();
        test_cdb_wakeup();
        test_bypass();
        test_full();
        test_clear();
        test_rdy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
